md_divider: RTL and testbench
=============================

Name: md_divider

Overview:
- Multi-cycle 32-bit radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU path.
- Sits directly downstream of the execute-stage mul/div control block. It consumes that block's start pulse, operands and signedness, and returns the quotient, remainder, a busy flag and a done pulse.
- The control block uses diven/divout_valid to drive its stall. It also suppresses restarts while busy or done.

Parameters:
DIV_W, 32, operand/result width; all arithmetic rules below are written for the default.

Ports:
clk  input  1  clock, all state updates on rising edge
cpurst_n  input  1  reset, asynchronous assert, active-low; synchronous deassert is supplied externally
dividend  input  DIV_W  numerator (rs1), sampled only on the start edge
divider  input  DIV_W  denominator (rs2), sampled only on the start edge
divsigned  input  1  1 = two's-complement operation, 0 = unsigned; sampled on the start edge
diven_p  input  1  start request; one-cycle pulse, honoured only in IDLE
quo  output  DIV_W  quotient, registered; held until the next result load
rem  output  DIV_W  remainder, registered; held until the next result load
diven  output  1  busy flag, high in CALC and FIX
divout_valid  output  1  result-ready flag, high for exactly one cycle (DONE state)

Behaviour:
- Reset (cpurst_n=0, asynchronous, any state including mid-operation):
  - state=IDLE; quo=0, rem=0, diven=0, divout_valid=0; iteration counter and working registers cleared.
  - A division in flight is discarded and no divout_valid is produced.
- States: IDLE, CALC, FIX, DONE. diven=(state==CALC||state==FIX); divout_valid=(state==DONE). Both are pure state decodes.
- IDLE:
  - diven_p=0 → stay.
  - diven_p=1 at edge E0 → capture operands.
    - Special cases (checked on raw operands at E0):
      - divider==0: quo=all ones (0xFFFFFFFF), rem=dividend; go to DONE. Applies in both signed and unsigned modes.
      - divsigned && dividend==0x80000000 && divider==0xFFFFFFFF: quo=0x80000000, rem=0; go to DONE.
    - Otherwise:
      - Store |dividend| and |divider|; absolute value is taken only when divsigned=1 and bit31=1.
      - Record q_neg = divsigned & (dividend[31]^divider[31]) and r_neg = divsigned & dividend[31].
      - Clear the partial remainder and counter; go to CALC.
- CALC:
  - One quotient bit per edge, MSB first.
  - Step: shift {partial_rem, dividend_reg} left by 1; trial = partial_rem_shifted − divisor; if trial ≥ 0 (no borrow) then keep trial and quotient bit=1, else restore and bit=0.
  - The partial remainder needs DIV_W+1 bits for the borrow test.
  - After exactly DIV_W iterations (edges E1..E32) → FIX.
- FIX (edge E33):
  - quo = q_neg ? −q : q; rem = r_neg ? −r : r; all results mod 2^32.
  - Go to DONE.
  - Remainder sign follows the dividend, giving RISC-V truncating semantics.
- DONE: divout_valid=1 for one cycle, then IDLE on the next edge unconditionally.
- Latency, counting the diven_p cycle as cycle 0:
  - Normal operation: divout_valid in cycle 34, diven high in cycles 1–33.
  - Special case: divout_valid in cycle 1, diven never asserted.
- quo/rem change only at the result-load edge (FIX→DONE, or IDLE→DONE for special cases). They are stable during DONE and held afterwards in IDLE. This lets a fused REM following a DIV reuse them.
- diven_p in CALC/FIX/DONE is ignored: no restart, operands are not re-sampled.
- diven_p at the DONE→IDLE edge is also ignored; a start is accepted only on an edge where state==IDLE.
- Operand changes after E0 have no effect on the result.

Test Plan:
- Unsigned 100/7: dividend=100, divider=7, divsigned=0 → diven high in cycles 1–33; divout_valid only in cycle 34; quo=14, rem=2; both held after return to IDLE.
- Signed −7/2: dividend=0xFFFFFFF9, divider=2, divsigned=1 → quo=0xFFFFFFFD (−3), rem=0xFFFFFFFF (−1). Also 7/−2 → quo=0xFFFFFFFD, rem=1.
- Divide by zero: 5/0 with divsigned=0 and with divsigned=1 → divout_valid in cycle 1, diven never high; quo=0xFFFFFFFF, rem=5.
- Overflow: 0x80000000/0xFFFFFFFF, divsigned=1 → quo=0x80000000, rem=0 in cycle 1. Same operands with divsigned=0 → full 34-cycle latency, quo=0, rem=0x80000000.
- Busy/start interaction:
  - diven_p re-pulsed in cycles 5 and 34 with different operands → ignored; the original result is delivered.
  - A new diven_p in cycle 35 → accepted; its divout_valid arrives in cycle 69.
- Reset mid-operation: assert cpurst_n=0 asynchronously in cycle 10 → diven, quo, rem and divout_valid go to 0 immediately. After release, no spurious divout_valid; a fresh 9/3 → quo=3, rem=0.

Source files
------------

// File: rtl/md_divider.sv
// ---------------------------------------------------------------------------
// md_divider
//   Multi-cycle radix-2 restoring divider serving the RV32M DIV/DIVU/REM/REMU
//   path. A start pulse in IDLE captures the operands. The divider then
//   produces one quotient bit per clock, fixes up the result signs, and
//   presents quotient and remainder together with a one-cycle done flag.
//
//   Divide-by-zero and signed overflow (MIN / -1) skip the iteration and
//   deliver their architectural results one cycle after the start.
//
// Ports
//   clk           in   clock, rising-edge
//   cpurst_n      in   asynchronous active-low reset
//   dividend      in   numerator, sampled on the accepted start edge
//   divider       in   denominator, sampled on the accepted start edge
//   divsigned     in   1 = two's-complement operation, 0 = unsigned
//   diven_p       in   start pulse, honoured only while IDLE
//   quo           out  quotient, registered, held until the next result
//   rem           out  remainder, registered, held until the next result
//   diven         out  busy (CALC or FIX)
//   divout_valid  out  result ready, high for exactly one cycle (DONE)
//   dbg_state     out  current FSM state, for checkers
//
// Handshake: diven_p is a fire-and-forget pulse with no ready. It is taken
// only on an edge where the FSM is in IDLE, and it is dropped silently in
// every other state. divout_valid is a pure decode of DONE and is not
// back-pressured. quo and rem are stable while it is high.
// ---------------------------------------------------------------------------
module md_divider #(
   parameter int DIV_W = 32
) (
   input  logic             clk,
   input  logic             cpurst_n,
   input  logic [DIV_W-1:0] dividend,
   input  logic [DIV_W-1:0] divider,
   input  logic             divsigned,
   input  logic             diven_p,
   output logic [DIV_W-1:0] quo,
   output logic [DIV_W-1:0] rem,
   output logic             diven,
   output logic             divout_valid,
   output logic [1:0]       dbg_state
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam int CNT_W = $clog2(DIV_W);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_W - 1);
   localparam logic [DIV_W-1:0] MIN_NEG   = {1'b1, {(DIV_W-1){1'b0}}};

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] dvd_q, dvd_d;    // shifts out dividend bits, shifts in quotient bits
   logic [DIV_W-1:0] dvs_q, dvs_d;    // |divisor|
   logic [DIV_W-1:0] prem_q, prem_d;  // partial remainder, always < divisor between steps
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [DIV_W-1:0] quo_q, quo_d;
   logic [DIV_W-1:0] rem_q, rem_d;

   // The shifted partial remainder can reach 2*divisor-1, so it needs one
   // extra bit for the borrow test. After a successful subtract the result
   // is below the divisor, so the low DIV_W bits are the whole value.
   logic [DIV_W:0]   shifted;
   logic             no_borrow;
   logic [DIV_W-1:0] trial;

   assign shifted   = {prem_q, dvd_q[DIV_W-1]};
   assign no_borrow = (shifted >= {1'b0, dvs_q});
   assign trial     = shifted[DIV_W-1:0] - dvs_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      prem_d  = prem_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      quo_d   = quo_q;
      rem_d   = rem_q;

      case (state_q)
         IDLE: begin
            if (diven_p) begin
               if (divider == '0) begin
                  quo_d   = '1;
                  rem_d   = dividend;
                  state_d = DONE;
               end else if (divsigned && (dividend == MIN_NEG) && (divider == '1)) begin
                  quo_d   = MIN_NEG;
                  rem_d   = '0;
                  state_d = DONE;
               end else begin
                  dvd_d   = (divsigned && dividend[DIV_W-1]) ? -dividend : dividend;
                  dvs_d   = (divsigned && divider[DIV_W-1])  ? -divider  : divider;
                  qneg_d  = divsigned & (dividend[DIV_W-1] ^ divider[DIV_W-1]);
                  rneg_d  = divsigned & dividend[DIV_W-1];
                  prem_d  = '0;
                  cnt_d   = '0;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (no_borrow) begin
               prem_d = trial;
               dvd_d  = {dvd_q[DIV_W-2:0], 1'b1};
            end else begin
               prem_d = shifted[DIV_W-1:0];
               dvd_d  = {dvd_q[DIV_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d = FIX;
            end
         end
         FIX: begin
            // Remainder takes the dividend's sign, giving truncating division.
            quo_d   = qneg_q ? -dvd_q  : dvd_q;
            rem_d   = rneg_q ? -prem_q : prem_q;
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge cpurst_n) begin
      if (!cpurst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         prem_q  <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         prem_q  <= prem_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
      end
   end

   assign quo          = quo_q;
   assign rem          = rem_q;
   assign diven        = (state_q == CALC) || (state_q == FIX);
   assign divout_valid = (state_q == DONE);
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_md_divider.sv
// ---------------------------------------------------------------------------
// tb_md_divider
//   Self-checking bench for md_divider. It covers the following:
//   - reset values;
//   - a table of directed vectors with hand-computed results;
//   - randomized operations checked against an arithmetic reference;
//   - start pulses arriving while the divider is busy or done;
//   - an asynchronous reset in the middle of an operation.
//   Cycle k means the k-th falling edge after the start pulse was driven.
//   The start pulse is driven in cycle 0.
// ---------------------------------------------------------------------------
module tb_md_divider;

   logic        clk;
   logic        cpurst_n;
   logic [31:0] dividend;
   logic [31:0] divider;
   logic        divsigned;
   logic        diven_p;
   logic [31:0] quo;
   logic [31:0] rem;
   logic        diven;
   logic        divout_valid;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   md_divider #(.DIV_W(32)) dut (
      .clk          (clk),
      .cpurst_n     (cpurst_n),
      .dividend     (dividend),
      .divider      (divider),
      .divsigned    (divsigned),
      .diven_p      (diven_p),
      .quo          (quo),
      .rem          (rem),
      .diven        (diven),
      .divout_valid (divout_valid),
      .dbg_state    (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- vector table ----------------
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] q;
      logic [31:0] r;
      int          lat;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs[NVEC];

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Built from RV32M rules using plain 64-bit arithmetic.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r, output int lat);
      longint sa, sb;
      if (b == 32'h0) begin
         q = 32'hFFFF_FFFF; r = a; lat = 1;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 32'h0; lat = 1;
      end else begin
         if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
         end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
         end
         q = 32'(sa / sb);
         r = 32'(sa % sb);
         lat = 34;
      end
   endfunction

   // ---------------- driver: one full operation ----------------
   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] eq, input logic [31:0] er,
                         input int elat);
      int          got_lat;
      int          busy_bad;
      logic        v, bz;
      logic [31:0] q_at, r_at;
      got_lat  = 0;
      busy_bad = 0;
      q_at     = 32'h0;
      r_at     = 32'h0;
      @(negedge clk);
      dividend  = a;
      divider   = b;
      divsigned = s;
      diven_p   = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         v  = divout_valid;
         bz = diven;
         if (k == 1) begin
            // Scramble operands: only the start edge may sample them.
            diven_p   = 1'b0;
            dividend  = $urandom;
            divider   = $urandom;
            divsigned = 1'($urandom_range(0, 1));
         end
         if (bz !== ((elat == 34) && (k <= 33))) busy_bad++;
         if (v === 1'b1) begin
            got_lat = k;
            q_at    = quo;
            r_at    = rem;
            break;
         end
      end
      chk({name, "_latency"}, 32'(got_lat), 32'(elat));
      chk({name, "_quo"}, q_at, eq);
      chk({name, "_rem"}, r_at, er);
      chk({name, "_busy_window"}, 32'(busy_bad), 32'd0);
      @(negedge clk);
      chk({name, "_valid_one_cycle"}, {31'h0, divout_valid}, 32'd0);
      chk({name, "_quo_held"}, quo, eq);
      chk({name, "_rem_held"}, rem, er);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] mq, mr;
      logic [31:0] ra, rb;
      logic        rs;
      int          mlat;
      int          v1, v2, busy_bad, spurious;
      logic [31:0] q1, r1, q2, r2;

      vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          34};
      vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  34};
      vecs[2]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          34};
      vecs[3]  = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1};
      vecs[4]  = '{32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          1};
      vecs[5]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1};
      vecs[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  34};
      vecs[7]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          34};
      vecs[8]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'd1,          32'd0,          34};
      vecs[9]  = '{32'd0,          32'd5,          1'b1, 32'd0,          32'd0,          34};
      vecs[10] = '{32'h8000_0000,  32'd2,          1'b1, 32'hC000_0000,  32'd0,          34};
      vecs[11] = '{32'hFFFF_FFFF,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1};
      vecs[12] = '{32'd3,          32'd10,         1'b0, 32'd0,          32'd3,          34};

      cpurst_n  = 1'b0;
      dividend  = 32'h0;
      divider   = 32'h0;
      divsigned = 1'b0;
      diven_p   = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("reset_quo", quo, 32'h0);
      chk("reset_rem", rem, 32'h0);
      chk("reset_diven", {31'h0, diven}, 32'h0);
      chk("reset_valid", {31'h0, divout_valid}, 32'h0);
      chk("reset_state", {30'h0, dbg_state}, 32'h0);
      cpurst_n = 1'b1;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < NVEC; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                vecs[i].q, vecs[i].r, vecs[i].lat);
      end

      // Randomized against the reference model
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 4))
            0:       rb = 32'($urandom_range(0, 15));
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = 32'h0;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
         rs = 1'($urandom_range(0, 1));
         model(ra, rb, rs, mq, mr, mlat);
         run_op($sformatf("rnd%0d", i), ra, rb, rs, mq, mr, mlat);
      end

      // Start pulses while busy / done are ignored; a start in cycle 35 is taken
      @(negedge clk);
      dividend  = 32'd100;
      divider   = 32'd7;
      divsigned = 1'b0;
      diven_p   = 1'b1;
      v1 = 0; v2 = 0; busy_bad = 0;
      q1 = 32'h0; r1 = 32'h0; q2 = 32'h0; r2 = 32'h0;
      for (int k = 1; k <= 110; k++) begin
         @(negedge clk);
         if (diven !== (((k >= 1) && (k <= 33)) || ((k >= 36) && (k <= 68)))) busy_bad++;
         if (divout_valid === 1'b1) begin
            if (v1 == 0) begin
               v1 = k; q1 = quo; r1 = rem;
            end else if (v2 == 0) begin
               v2 = k; q2 = quo; r2 = rem;
            end
         end
         if (k == 35) chk("busy_quo_held_after_done", quo, 32'd14);
         diven_p = 1'b0;
         if (k == 5) begin
            diven_p = 1'b1; dividend = 32'd1234; divider = 32'd5; divsigned = 1'b1;
         end
         if (k == 34) begin
            diven_p = 1'b1; dividend = 32'hFFFF_0000; divider = 32'd3; divsigned = 1'b0;
         end
         if (k == 35) begin
            diven_p = 1'b1; dividend = 32'd1000; divider = 32'd10; divsigned = 1'b0;
         end
         if (v2 != 0) break;
      end
      chk("busy_first_valid_cycle", 32'(v1), 32'd34);
      chk("busy_first_quo", q1, 32'd14);
      chk("busy_first_rem", r1, 32'd2);
      chk("busy_second_valid_cycle", 32'(v2), 32'd69);
      chk("busy_second_quo", q2, 32'd100);
      chk("busy_second_rem", r2, 32'd0);
      chk("busy_diven_window", 32'(busy_bad), 32'd0);

      // Asynchronous reset in the middle of an operation
      @(negedge clk);
      dividend  = 32'd100;
      divider   = 32'd7;
      divsigned = 1'b0;
      diven_p   = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         diven_p = 1'b0;
      end
      chk("midrst_busy_before", {31'h0, diven}, 32'd1);
      cpurst_n = 1'b0;
      #1;
      chk("midrst_diven", {31'h0, diven}, 32'd0);
      chk("midrst_valid", {31'h0, divout_valid}, 32'd0);
      chk("midrst_quo", quo, 32'd0);
      chk("midrst_rem", rem, 32'd0);
      repeat (2) @(negedge clk);
      cpurst_n = 1'b1;
      spurious = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (divout_valid !== 1'b0 || diven !== 1'b0) spurious++;
      end
      chk("midrst_no_spurious", 32'(spurious), 32'd0);
      run_op("after_rst_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 34);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog: the sequence above is bounded, so this is a backstop.
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
